// File: rtl/up_link_tx_arbiter.sv
// N-source packet-atomic round-robin arbiter feeding one MAC TX AXI-Stream port.
// Define UP_LINK_TRUNC_EN to truncate packets longer than P_MAX_LENGTH and flush the remainder.
module up_link_tx_arbiter #(
  parameter int unsigned P_SRC_NUM    = 4,
  parameter int unsigned P_DATA_WIDTH = 64,
  parameter logic [14:0] P_MAX_LENGTH = 15'd9600
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_link_up,
  input  logic [P_SRC_NUM-1:0]                  s_axis_tvalid,
  input  logic [P_SRC_NUM*P_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [P_SRC_NUM*(P_DATA_WIDTH/8)-1:0] s_axis_tkeep,
  input  logic [P_SRC_NUM-1:0]                  s_axis_tlast,
  input  logic [P_SRC_NUM-1:0]                  s_axis_tuser,
  output logic [P_SRC_NUM-1:0]                  s_axis_tready,
  output logic                                  m_axis_tvalid,
  output logic [P_DATA_WIDTH-1:0]               m_axis_tdata,
  output logic [P_DATA_WIDTH/8-1:0]             m_axis_tkeep,
  output logic                                  m_axis_tlast,
  output logic                                  m_axis_tuser,
  input  logic                                  m_axis_tready,
  output logic [P_SRC_NUM-1:0]                  o_grant,
  output logic [31:0]                           o_pkt_cnt,
  output logic [15:0]                           o_trunc_cnt
);

  localparam int unsigned K         = P_DATA_WIDTH / 8;
  localparam int unsigned SW        = (P_SRC_NUM > 1) ? $clog2(P_SRC_NUM) : 1;
  localparam int unsigned MAX_BEATS = (32'(P_MAX_LENGTH) + K - 1) / K;
  localparam int unsigned BW        = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

  state_t              state;
  logic [SW-1:0]       rr_ptr;
  logic [BW-1:0]       beat_cnt;

  logic                win_found;
  logic [SW-1:0]       win_idx;
  logic [SW-1:0]       cand;
  logic                sel_valid;
  logic                sel_last;
  logic                sel_user;
  logic [P_DATA_WIDTH-1:0] sel_data;
  logic [K-1:0]        sel_keep;
  logic                out_ready;
  logic                accept;
  logic                flush_end;
  logic                trunc_hit;

  // While granted, rr_ptr holds the owner index, so it doubles as the data mux select
  always_comb begin
    sel_valid = s_axis_tvalid[rr_ptr];
    sel_last  = s_axis_tlast[rr_ptr];
    sel_user  = s_axis_tuser[rr_ptr];
    sel_data  = s_axis_tdata[32'(rr_ptr)*P_DATA_WIDTH +: P_DATA_WIDTH];
    sel_keep  = s_axis_tkeep[32'(rr_ptr)*K +: K];
  end

  // First valid source strictly after rr_ptr, searching circularly
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    cand      = rr_ptr;
    for (int unsigned k = 1; k <= P_SRC_NUM; k++) begin
      cand = SW'((32'(rr_ptr) + k) % P_SRC_NUM);
      if (!win_found && s_axis_tvalid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign out_ready = ~m_axis_tvalid | m_axis_tready;
  assign accept    = (state == SEND) && sel_valid && out_ready;
  assign flush_end = (state == FLUSH) && sel_valid && sel_last;

  always_comb begin
    s_axis_tready = '0;
    if (state == SEND)
      s_axis_tready = o_grant & {P_SRC_NUM{out_ready}};
    else if (state == FLUSH)
      s_axis_tready = o_grant;
  end

`ifdef UP_LINK_TRUNC_EN
  assign trunc_hit = accept && !sel_last && (beat_cnt == BW'(MAX_BEATS - 1));
`else
  assign trunc_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      rr_ptr        <= SW'(P_SRC_NUM - 1);
      beat_cnt      <= '0;
      o_grant       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      o_pkt_cnt     <= '0;
      o_trunc_cnt   <= '0;
    end else begin
      // Output register: load on accept, drop valid once the MAC takes the held beat
      if (accept) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= sel_data;
        m_axis_tkeep  <= sel_keep;
        m_axis_tlast  <= sel_last | trunc_hit;
        m_axis_tuser  <= sel_user | trunc_hit;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
        o_pkt_cnt <= o_pkt_cnt + 32'd1;

      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (i_link_up && win_found) begin
            o_grant <= P_SRC_NUM'(1) << win_idx;
            rr_ptr  <= win_idx;
            state   <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            beat_cnt <= beat_cnt + BW'(1);
            if (sel_last) begin
              state   <= IDLE;
              o_grant <= '0;
            end else if (trunc_hit) begin
              state <= FLUSH;
              if (o_trunc_cnt != 16'hFFFF)
                o_trunc_cnt <= o_trunc_cnt + 16'd1;
            end
          end
        end
        FLUSH: begin
          if (flush_end) begin
            state   <= IDLE;
            o_grant <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_up_link_tx_arbiter.sv
// Randomized self-checking bench for up_link_tx_arbiter with a packet-level round-robin model.
module tb_up_link_tx_arbiter;

  localparam int N = 4;
  localparam int W = 64;
  localparam int K = 8;
`ifdef UP_LINK_TRUNC_EN
  localparam logic [14:0] MAXLEN = 15'd64;
`else
  localparam logic [14:0] MAXLEN = 15'd9600;
`endif
  localparam int MAXB = (int'(MAXLEN) + K - 1) / K;

  typedef struct packed {
    logic [W-1:0] data;
    logic [K-1:0] keep;
    logic         last;
    logic         user;
  } beat_t;

  logic             clk;
  logic             rst;
  logic             link_up;
  logic [N-1:0]     s_tvalid;
  logic [N*W-1:0]   s_tdata;
  logic [N*K-1:0]   s_tkeep;
  logic [N-1:0]     s_tlast;
  logic [N-1:0]     s_tuser;
  logic [N-1:0]     s_tready;
  logic             m_tvalid;
  logic [W-1:0]     m_tdata;
  logic [K-1:0]     m_tkeep;
  logic             m_tlast;
  logic             m_tuser;
  logic             m_tready;
  logic [N-1:0]     grant;
  logic [31:0]      pkt_cnt;
  logic [15:0]      trunc_cnt;

  int checks = 0;
  int errors = 0;
  int exp_rr;
  int exp_pkt;
  int exp_trunc;
  beat_t src_q[N][$];
  int    len_q[N][$];

  up_link_tx_arbiter #(
    .P_SRC_NUM(N), .P_DATA_WIDTH(W), .P_MAX_LENGTH(MAXLEN)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_link_up(link_up),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .o_grant(grant), .o_pkt_cnt(pkt_cnt), .o_trunc_cnt(trunc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    b.data = {$urandom, $urandom};
    b.keep = 8'($urandom);
    b.last = last;
    b.user = ($urandom_range(7) == 0);
    return b;
  endfunction

  task automatic add_pkt(input int s, input int len);
    for (int b = 0; b < len; b++) src_q[s].push_back(rand_beat(b == len - 1));
    len_q[s].push_back(len);
  endtask

  task automatic drive_idle();
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tuser = '0;
  endtask

  task automatic drive_beat(input int s, input beat_t b);
    s_tvalid[s] = 1'b1;
    s_tdata[s*W +: W] = b.data;
    s_tkeep[s*K +: K] = b.keep;
    s_tlast[s] = b.last;
    s_tuser[s] = b.user;
  endtask

  function automatic beat_t out_beat();
    beat_t g;
    g.data = m_tdata; g.keep = m_tkeep; g.last = m_tlast; g.user = m_tuser;
    return g;
  endfunction

  // Drives the queued packets of every source, checks output order, grants and counters
  task automatic run_engine(input string name, input int gap_pct, input int stall_pct,
                            input bit chk_bubble);
    beat_t exp_q[$];
    beat_t got_q[$];
    int exp_g[$];
    logic [N-1:0] got_g[$];
    logic [N-1:0] eg;
    int out_cyc[$];
    int off[N];
    int idx[N];
    bit start[N];
    bit hold[N];
    bit v[N];
    logic [N-1:0] hs;
    logic [N-1:0] prev_g;
    int p, f, len, cyc, leak;
    bit done, drained;
    beat_t bt;

    p = exp_rr;
    for (int i = 0; i < N; i++) off[i] = 0;
    forever begin
      f = -1;
      for (int k = 1; k <= N; k++)
        if (f < 0 && len_q[(p + k) % N].size() > 0) f = (p + k) % N;
      if (f < 0) break;
      len = len_q[f].pop_front();
      for (int b = 0; b < len; b++) begin
        bt = src_q[f][off[f] + b];
        if (b < MAXB) begin
          if (len > MAXB && b == MAXB - 1) begin bt.last = 1'b1; bt.user = 1'b1; end
          exp_q.push_back(bt);
        end
      end
      if (len > MAXB) exp_trunc++;
      off[f] += len;
      exp_g.push_back(f);
      exp_pkt++;
      p = f;
    end
    exp_rr = p;

    for (int i = 0; i < N; i++) begin idx[i] = 0; start[i] = 1; hold[i] = 0; end
    prev_g = '0; cyc = 0; done = 0; leak = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      drive_idle();
      for (int i = 0; i < N; i++) begin
        v[i] = 0;
        if (idx[i] < src_q[i].size()) begin
          v[i] = start[i] || hold[i] || ($urandom_range(99) >= gap_pct);
          if (v[i]) drive_beat(i, src_q[i][idx[i]]);
        end
      end
      m_tready = ($urandom_range(99) >= stall_pct);
      #1;
      if (m_tvalid && m_tready) begin got_q.push_back(out_beat()); out_cyc.push_back(cyc); end
      if (grant != '0 && prev_g == '0) got_g.push_back(grant);
      prev_g = grant;
      if ((s_tready & ~grant) != '0) leak++;
      hs = s_tvalid & s_tready;
      @(posedge clk);
      drained = 1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin start[i] = src_q[i][idx[i]].last; idx[i]++; hold[i] = 0; end
        else hold[i] = v[i];
        if (idx[i] < src_q[i].size()) drained = 0;
      end
      done = drained && (got_q.size() >= exp_q.size());
      cyc++;
    end
    @(negedge clk);
    drive_idle();
    m_tready = 1'b1;
    #1;

    checks++;
    if (!done) begin errors++; $display("FAIL %s timeout got %0d beats need %0d", name, got_q.size(), exp_q.size()); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s beat_count got %0d exp %0d", name, got_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      checks++;
      if (got_q[j] !== exp_q[j]) begin
        errors++; $display("FAIL %s beat %0d got %h exp %h", name, j, got_q[j], exp_q[j]);
      end
    end
    checks++;
    if (got_g.size() != exp_g.size()) begin
      errors++; $display("FAIL %s grant_count got %0d exp %0d", name, got_g.size(), exp_g.size());
    end
    for (int j = 0; j < exp_g.size() && j < got_g.size(); j++) begin
      eg = '0; eg[exp_g[j]] = 1'b1;
      checks++;
      if (got_g[j] !== eg) begin
        errors++; $display("FAIL %s grant %0d got %b exp %b", name, j, got_g[j], eg);
      end
    end
    if (chk_bubble) begin
      for (int j = 1; j < out_cyc.size(); j++) begin
        checks++;
        if (out_cyc[j] - out_cyc[j-1] != 2) begin
          errors++; $display("FAIL %s bubble %0d got spacing %0d exp 2", name, j, out_cyc[j] - out_cyc[j-1]);
        end
      end
    end
    checks++;
    if (leak != 0) begin errors++; $display("FAIL %s ready_leak got %0d cycles exp 0", name, leak); end
    checks++;
    if (pkt_cnt !== 32'(exp_pkt)) begin errors++; $display("FAIL %s pkt_cnt got %0d exp %0d", name, pkt_cnt, exp_pkt); end
    checks++;
    if (trunc_cnt !== 16'(exp_trunc)) begin errors++; $display("FAIL %s trunc_cnt got %0d exp %0d", name, trunc_cnt, exp_trunc); end
    for (int i = 0; i < N; i++) src_q[i].delete();
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser} !== '0) begin
      errors++; $display("FAIL %s m_axis got %b/%h/%h/%b/%b exp zero", name, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser);
    end
    checks++;
    if ({grant, s_tready} !== '0) begin errors++; $display("FAIL %s grant/ready got %b/%b exp 0", name, grant, s_tready); end
    checks++;
    if ({pkt_cnt, trunc_cnt} !== '0) begin errors++; $display("FAIL %s counters got %0d/%0d exp 0", name, pkt_cnt, trunc_cnt); end
  endtask

  task automatic test_reset();
    rst = 1'b1; link_up = 1'b1; m_tready = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_rr = N - 1; exp_pkt = 0; exp_trunc = 0;
    #1;
    check_zero("reset");
  endtask

  task automatic test_two_src();
    add_pkt(0, 3);
    add_pkt(2, 3);
    run_engine("two_src", 0, 0, 1'b0);
  endtask

  task automatic test_round_robin();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) add_pkt(s, 1);
    run_engine("round_robin", 0, 0, 1'b1);
  endtask

  // Output stalls for two cycles mid-packet; beat must hold and source ready must follow
  task automatic test_stall();
    int tr[16] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    beat_t d[4];
    beat_t got[$];
    logic [W-1:0] prev_data;
    bit prev_stall;
    bit hs;
    int sent, low_cnt;
    logic exp_rdy;
    for (int b = 0; b < 4; b++) d[b] = rand_beat(b == 3);
    sent = 0; low_cnt = 0; prev_stall = 0; prev_data = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      drive_idle();
      if (sent < 4) drive_beat(1, d[sent]);
      m_tready = tr[c][0];
      #1;
      if (sent < 4) begin
        exp_rdy = (c == 0) ? 1'b0 : tr[c][0];
        checks++;
        if (s_tready[1] !== exp_rdy) begin
          errors++; $display("FAIL stall ready c%0d got %b exp %b", c, s_tready[1], exp_rdy);
        end
        if (c > 0 && !s_tready[1]) low_cnt++;
      end
      if (prev_stall) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== prev_data) begin
          errors++; $display("FAIL stall hold c%0d got %b/%h exp 1/%h", c, m_tvalid, m_tdata, prev_data);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data = m_tdata;
      if (m_tvalid && m_tready) got.push_back(out_beat());
      hs = s_tvalid[1] && s_tready[1];
      @(posedge clk);
      if (hs) sent++;
    end
    checks++;
    if (low_cnt != 2) begin errors++; $display("FAIL stall low_cycles got %0d exp 2", low_cnt); end
    checks++;
    if (got.size() != 4) begin errors++; $display("FAIL stall beats got %0d exp 4", got.size()); end
    for (int b = 0; b < 4 && b < got.size(); b++) begin
      checks++;
      if (got[b] !== d[b]) begin errors++; $display("FAIL stall data %0d got %h exp %h", b, got[b], d[b]); end
    end
    exp_pkt++; exp_rr = 1;
  endtask

  // Link down blocks the grant; first output beat two cycles after link rises
  task automatic test_link();
    beat_t b;
    b = rand_beat(1'b1);
    @(negedge clk);
    link_up = 1'b0; m_tready = 1'b1;
    drive_idle();
    drive_beat(1, b);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++;
      if (s_tready !== '0 || grant !== '0 || m_tvalid !== 1'b0) begin
        errors++; $display("FAIL link_down c%0d ready %b grant %b valid %b exp 0", c, s_tready, grant, m_tvalid);
      end
    end
    @(negedge clk);
    link_up = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (m_tvalid !== 1'b0 || grant !== 4'b0010) begin
      errors++; $display("FAIL link_n1 valid %b grant %b exp 0/0010", m_tvalid, grant);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (m_tvalid !== 1'b1 || out_beat() !== b) begin
      errors++; $display("FAIL link_n2 valid %b beat %h exp 1/%h", m_tvalid, out_beat(), b);
    end
    @(posedge clk);
    exp_pkt++; exp_rr = 1;
  endtask

`ifdef UP_LINK_TRUNC_EN
  task automatic test_trunc();
    add_pkt(0, 12);
    add_pkt(2, 2);
    run_engine("trunc", 0, 0, 1'b0);
  endtask
`endif

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < N; s++)
        for (int p = $urandom_range(3); p > 0; p--) add_pkt(s, $urandom_range(1, 12));
      run_engine("random", 30, 30, 1'b0);
    end
  endtask

  // Async reset during beat 2 of a 5-beat packet, then arbitration restarts at source 0
  task automatic test_reset_mid();
    beat_t d[5];
    int sent;
    bit hs;
    for (int b = 0; b < 5; b++) d[b] = rand_beat(b == 4);
    sent = 0;
    m_tready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_idle();
      drive_beat(2, d[sent]);
      #1;
      hs = s_tvalid[2] && s_tready[2];
      @(posedge clk);
      if (hs) sent++;
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_zero("reset_mid");
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    exp_rr = N - 1; exp_pkt = 0; exp_trunc = 0;
    add_pkt(3, 2);
    add_pkt(0, 3);
    run_engine("after_reset", 0, 0, 1'b0);
  endtask

  initial begin
    drive_idle();
    rst = 1'b1; link_up = 1'b0; m_tready = 1'b0;
    test_reset();
    test_two_src();
    test_round_robin();
    test_stall();
    test_link();
`ifdef UP_LINK_TRUNC_EN
    test_trunc();
`endif
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
